// File: rtl/line_memory_pkg.sv
// Shared constants and types for line_memory: cacheline width, line-index
// bit range, service FSM states and the read-queue entry layout.
package line_memory_pkg;

  localparam int LINE_W = 128;
  localparam int IDX_HI = 9;
  localparam int IDX_LO = 4;
  localparam int IDX_W  = IDX_HI - IDX_LO + 1;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic              client_id;
  } fifo_entry_t;

endpackage

// File: rtl/line_memory_fifo.sv
// Read queue for line_memory: DEPTH-entry FIFO of {line, client_id} with
// occupancy count; simultaneous push and pop leave the count unchanged.
module line_memory_fifo
  import line_memory_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  fifo_entry_t              wdata,
  output fifo_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and count alone decide
  // which entries are live, which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/line_memory.sv
// Line memory with a queued fixed-latency read path. Optional macro
// LINE_MEMORY_STATS_EN adds saturating rd_count/wr_count outputs.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 4,
  parameter int LINES   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   rden,
  input  logic                   wren,
  input  logic [31:0]            addr_in,
  input  logic [LINE_W-1:0]      data_in,
  input  logic                   client_id_in,
  output logic                   req_ready,
  output logic [LINE_W-1:0]      data_out,
  output logic                   data_out_valid,
  output logic                   client_id_out,
  output logic [$clog2(DEPTH):0] pending_count
`ifdef LINE_MEMORY_STATS_EN
  ,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
`endif
);

  localparam int                CW       = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 2);

  logic [LINE_W-1:0] lines_q [LINES];
  logic [IDX_W-1:0]  line_idx;
  logic              accept;
  logic              push;
  logic              pop;
  logic              load_out;
  logic              fifo_full;
  logic              fifo_empty;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  next_cnt;
  logic              unused_addr;

  assign unused_addr = ^{addr_in[31:IDX_HI+1], addr_in[IDX_LO-1:0]};
  assign line_idx    = addr_in[IDX_HI:IDX_LO];
  assign req_ready   = !fifo_full;
  assign accept      = en && req_ready && (rden || wren);
  assign push        = accept && rden;

  // A same-cycle write is forwarded so the read sees the new line.
  assign push_entry.line      = wren ? data_in : lines_q[line_idx];
  assign push_entry.client_id = client_id_in;

  always_ff @(posedge clk) begin
    if (accept && wren) lines_q[line_idx] <= data_in;
  end

  line_memory_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending_count)
  );

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    pop        = 1'b0;
    load_out   = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            next_state = WAIT;
            next_cnt   = CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            next_state = RESP;
            load_out   = 1'b1;
          end else begin
            next_cnt = cnt - CNT_W'(1);
          end
        end
        RESP: begin
          pop = 1'b1;
          if ((pending_count > CW'(1)) || push) begin
            next_state = WAIT;
            next_cnt   = CNT_LOAD;
          end else begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      data_out      <= '0;
      client_id_out <= 1'b0;
    end else if (en) begin
      state <= next_state;
      cnt   <= next_cnt;
      if (load_out) begin
        data_out      <= head.line;
        client_id_out <= head.client_id;
      end
    end
  end

  assign data_out_valid = en && (state == RESP);

`ifdef LINE_MEMORY_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (accept && rden && (rd_count != '1)) rd_count <= rd_count + 32'd1;
      if (accept && wren && (wr_count != '1)) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_memory.sv
// Directed self-checking bench for line_memory (LATENCY=5, DEPTH=4).
module tb_line_memory;

  localparam int LATENCY = 5;
  localparam int DEPTH   = 4;
  localparam int LINES   = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         rden;
  logic         wren;
  logic [31:0]  addr_in;
  logic [127:0] data_in;
  logic         client_id_in;
  logic         req_ready;
  logic [127:0] data_out;
  logic         data_out_valid;
  logic         client_id_out;
  logic [2:0]   pending_count;
`ifdef LINE_MEMORY_STATS_EN
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] D1  = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] OLD = 128'h01234567_89ABCDEF_00112233_44556677;
  localparam logic [127:0] NEW = 128'hFEDCBA98_76543210_FFEEDDCC_BBAA9988;
  localparam logic [127:0] K   = {8{16'h5A3C}};

  always #5 clk = ~clk;

  line_memory #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .LINES   (LINES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .rden           (rden),
    .wren           (wren),
    .addr_in        (addr_in),
    .data_in        (data_in),
    .client_id_in   (client_id_in),
    .req_ready      (req_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .client_id_out  (client_id_out),
    .pending_count  (pending_count)
`ifdef LINE_MEMORY_STATS_EN
    ,
    .rd_count       (rd_count),
    .wr_count       (wr_count)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [127:0] d);
    addr_in = a; data_in = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic c);
    addr_in = a; client_id_in = c; rden = 1'b1;
    tick();
    rden = 1'b0;
  endtask

  // Bounded wait: k returns 100 if no strobe appears, which then fails the latency compare.
  task automatic wait_valid(output int k);
    k = 0;
    while (!data_out_valid && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; rden = 1'b0; wren = 1'b0;
    addr_in = '0; data_in = '0; client_id_in = 1'b0;
    repeat (2) tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (pending_count !== 3'd0) begin n_err++; $display("FAIL reset_pending: got %0d want 0", pending_count); end
    n_cmp++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
    n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_cmp++; if (client_id_out !== 1'b0) begin n_err++; $display("FAIL reset_client: got %b want 0", client_id_out); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_write_read;
    int k;
    do_write(32'h100, D1);
    n_cmp++; if (data_out_valid !== 1'b0 || pending_count !== 3'd0) begin n_err++; $display("FAIL wr_no_resp: got valid=%b pending=%0d want 0/0", data_out_valid, pending_count); end
    do_read(32'h100, 1'b1);
    n_cmp++; if (pending_count !== 3'd1) begin n_err++; $display("FAIL rd_pending: got %0d want 1", pending_count); end
    wait_valid(k);
    n_cmp++; if (k != LATENCY) begin n_err++; $display("FAIL rd_latency: got %0d want %0d", k, LATENCY); end
    n_cmp++; if (data_out !== D1) begin n_err++; $display("FAIL rd_data: got %h want %h", data_out, D1); end
    n_cmp++; if (client_id_out !== 1'b1) begin n_err++; $display("FAIL rd_client: got %b want 1", client_id_out); end
    tick();
    n_cmp++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL rd_one_cycle: got %b want 0", data_out_valid); end
    repeat (3) tick();
    n_cmp++; if (data_out !== D1 || pending_count !== 3'd0) begin n_err++; $display("FAIL rd_hold: got %h/%0d want %h/0", data_out, pending_count, D1); end
  endtask

  task automatic test_bypass;
    int k;
    addr_in = 32'h200; data_in = A5; client_id_in = 1'b0; rden = 1'b1; wren = 1'b1;
    tick();
    rden = 1'b0; wren = 1'b0;
    n_cmp++; if (pending_count !== 3'd1) begin n_err++; $display("FAIL byp_pending: got %0d want 1", pending_count); end
    wait_valid(k);
    n_cmp++; if (k != LATENCY) begin n_err++; $display("FAIL byp_latency: got %0d want %0d", k, LATENCY); end
    n_cmp++; if (data_out !== A5 || client_id_out !== 1'b0) begin n_err++; $display("FAIL byp_data: got %h/%b want %h/0", data_out, client_id_out, A5); end
    repeat (2) tick();
  endtask

  task automatic test_stale;
    int k;
    do_write(32'h300, OLD);
    do_read(32'h300, 1'b1);
    do_write(32'h300, NEW);
    wait_valid(k);
    n_cmp++; if (k != LATENCY - 1) begin n_err++; $display("FAIL stale_latency: got %0d want %0d", k + 1, LATENCY); end
    n_cmp++; if (data_out !== OLD) begin n_err++; $display("FAIL stale_data: got %h want %h", data_out, OLD); end
    repeat (2) tick();
    do_read(32'h300, 1'b0);
    wait_valid(k);
    n_cmp++; if (data_out !== NEW) begin n_err++; $display("FAIL stale_new_data: got %h want %h", data_out, NEW); end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back;
    logic [127:0] exp_line [5];
    logic [127:0] rsp_d [5];
    logic         rsp_c [5];
    int           acc_t [5];
    int           rsp_t [5];
    int           n_acc = 0;
    int           n_rsp = 0;
    int           cyc = 0;
    bit           accepted;
    for (int i = 0; i < 5; i++) begin
      exp_line[i] = {4{32'hC0DE0000 + 32'(i)}};
      do_write(32'h040 + 32'(i * 16), exp_line[i]);
      acc_t[i] = -1; rsp_t[i] = -1; rsp_d[i] = '0; rsp_c[i] = 1'b0;
    end
    addr_in = 32'h040; client_id_in = 1'b0; rden = 1'b1;
    while (n_rsp < 5 && cyc < 200) begin
      accepted = rden && req_ready;
      tick();
      cyc++;
      if (accepted) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        if (n_acc == 4) begin
          n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b want 0", req_ready); end
          n_cmp++; if (pending_count !== 3'd4) begin n_err++; $display("FAIL b2b_full_pending: got %0d want 4", pending_count); end
        end
        if (n_acc < 5) begin
          addr_in = 32'h040 + 32'(n_acc * 16);
          client_id_in = 1'(n_acc & 1);
        end else begin
          rden = 1'b0;
        end
      end
      if (data_out_valid && n_rsp < 5) begin
        rsp_t[n_rsp] = cyc; rsp_d[n_rsp] = data_out; rsp_c[n_rsp] = client_id_out;
        n_rsp++;
      end
    end
    rden = 1'b0;
    n_cmp++; if (n_rsp != 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", n_rsp); end
    n_cmp++; if (acc_t[4] != acc_t[0] + LATENCY + 2) begin n_err++; $display("FAIL b2b_fifth_accept: got cycle %0d want %0d", acc_t[4], acc_t[0] + LATENCY + 2); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_t[i] != acc_t[0] + LATENCY * (i + 1)) begin n_err++; $display("FAIL b2b_time[%0d]: got %0d want %0d", i, rsp_t[i], acc_t[0] + LATENCY * (i + 1)); end
      n_cmp++; if (rsp_d[i] !== exp_line[i] || rsp_c[i] !== 1'(i & 1)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", i, rsp_d[i], rsp_c[i], exp_line[i], 1'(i & 1)); end
    end
    repeat (2) tick();
  endtask

  task automatic test_en_stall;
    int k;
    do_write(32'h0A0, K);
    do_read(32'h200, 1'b1);
    repeat (2) tick();
    en = 1'b0;
    addr_in = 32'h0A0; data_in = NEW; wren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (data_out_valid !== 1'b0 || pending_count !== 3'd1) begin n_err++; $display("FAIL stall_hold[%0d]: got valid=%b pending=%0d want 0/1", i, data_out_valid, pending_count); end
    end
    wren = 1'b0; en = 1'b1;
    wait_valid(k);
    n_cmp++; if (k + 5 != LATENCY + 3) begin n_err++; $display("FAIL stall_latency: got %0d want %0d", k + 5, LATENCY + 3); end
    n_cmp++; if (data_out !== A5) begin n_err++; $display("FAIL stall_data: got %h want %h", data_out, A5); end
    repeat (2) tick();
    do_read(32'h0A0, 1'b0);
    wait_valid(k);
    n_cmp++; if (k != LATENCY) begin n_err++; $display("FAIL resp_latency: got %0d want %0d", k, LATENCY); end
    en = 1'b0;
    #1;
    n_cmp++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL resp_en_low: got %b want 0", data_out_valid); end
    repeat (2) tick();
    n_cmp++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL resp_en_low_hold: got %b want 0", data_out_valid); end
    en = 1'b1;
    #1;
    n_cmp++; if (data_out_valid !== 1'b1 || data_out !== K) begin n_err++; $display("FAIL resp_resume: got %b/%h want 1/%h", data_out_valid, data_out, K); end
    tick();
    n_cmp++; if (data_out_valid !== 1'b0 || pending_count !== 3'd0) begin n_err++; $display("FAIL resp_pop: got valid=%b pending=%0d want 0/0", data_out_valid, pending_count); end
    repeat (2) tick();
  endtask

  task automatic test_reset_midop;
    int seen = 0;
    rden = 1'b1; addr_in = 32'h100;
    for (int i = 0; i < 3; i++) begin
      client_id_in = 1'(i & 1);
      tick();
    end
    rden = 1'b0;
    n_cmp++; if (pending_count !== 3'd3) begin n_err++; $display("FAIL mid_pending: got %0d want 3", pending_count); end
    tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (pending_count !== 3'd0 || req_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_state: got pending=%0d ready=%b want 0/1", pending_count, req_ready); end
    n_cmp++; if (data_out_valid !== 1'b0 || data_out !== '0) begin n_err++; $display("FAIL mid_reset_out: got %b/%h want 0/0", data_out_valid, data_out); end
`ifdef LINE_MEMORY_STATS_EN
    n_cmp++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_err++; $display("FAIL mid_reset_stats: got %0d/%0d want 0/0", rd_count, wr_count); end
`endif
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (data_out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_no_resp: got %0d strobes want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_stale();
    test_back_to_back();
    test_en_stall();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter LATENCY, default 5: edge count from read acceptance to response; legal range 2..15.
REQ-002 Parameter DEPTH, default 4: read-queue entries; power of two.
REQ-003 Parameter LINES, default 64: 128-bit lines stored; index = addr_in[9:4].
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 en  input  1  downstream enable; low freezes all state.
REQ-007 rden  input  1  read request.
REQ-008 wren  input  1  write request.
REQ-009 addr_in  input  32  byte address; bits [3:0] ignored.
REQ-010 data_in  input  128  write cacheline.
REQ-011 client_id_in  input  1  requester id (0 = A, 1 = B).
REQ-012 req_ready  output  1  request accepted this cycle if high.
REQ-013 data_out  output  128  read response line.
REQ-014 data_out_valid  output  1  one-cycle response strobe.
REQ-015 client_id_out  output  1  id of the response, valid with data_out_valid.
REQ-016 pending_count  output  $clog2(DEPTH)+1  queued plus in-service reads.

Function
REQ-017 Acceptance: a request is accepted on an edge where en=1, req_ready=1 and (rden|wren)=1; req_ready = (pending_count < DEPTH).
REQ-018 Write: an accepted wren writes data_in to line addr_in[9:4] on the accepting edge; no response generated.
REQ-019 Read: an accepted rden pushes {line contents, client_id_in} into the FIFO on the accepting edge; contents captured at acceptance, so later writes do not alter queued data.
REQ-020 rden and wren both set in the same accepted cycle: write commits, read captures data_in (write-before-read bypass), one FIFO entry pushed.
REQ-021 Service FSM states: IDLE, WAIT, RESP.
REQ-022 IDLE -> WAIT when the FIFO is non-empty and en=1; down-counter loaded with LATENCY-2.
REQ-023 WAIT decrements while en=1; at 0 moves to RESP.
REQ-024 RESP: data_out/client_id_out driven from the FIFO head, data_out_valid=1 for exactly one cycle, head popped; next state WAIT (counter reloaded) if another entry remains, else IDLE.
REQ-025 Latency: read accepted on edge E into an empty FIFO with FSM IDLE and en held high -> data_out_valid high in the cycle after edge E+LATENCY.
REQ-026 Back-to-back queued reads respond in acceptance order, spaced LATENCY cycles apart.
REQ-027 en=0: no acceptance, no push, no pop, counter and FSM hold; data_out_valid forced 0 while en=0 and raised again on resumption.
REQ-028 Full: pending_count = DEPTH forces req_ready=0; a push and a pop on the same edge are legal and leave the count unchanged.
REQ-029 Requests presented while req_ready=0 are ignored; the upstream holds them.
REQ-030 FIFO pointers wrap modulo DEPTH with no lost or duplicated entries.
REQ-031 data_out holds its last value between responses.

Reset
REQ-032 Asserting reset clears the FIFO, sets the FSM to IDLE and the counter to 0, drives data_out=0, data_out_valid=0, client_id_out=0, pending_count=0 and req_ready=1 (stats counters 0 if present).
REQ-033 Line storage is not reset; contents are undefined until written.
REQ-034 Reset mid-operation discards all queued and in-service reads; no response is issued for them.

Configuration
REQ-035 Macro LINE_MEMORY_STATS_EN defined: add outputs rd_count and wr_count (32 bits each), incremented on each accepted read and write, saturating at all-ones.
REQ-036 Macro LINE_MEMORY_STATS_EN absent: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-037 Shared package holds the cacheline width (128), the line-index bit range, the FSM state enum, and the FIFO entry type {line, client_id}.
REQ-038 The read queue is a separate sub-module, line_memory_fifo (push, pop, full, empty, count); the FSM, storage and bypass stay in line_memory.

Verification
REQ-039 Write 0xDEADBEEF_..._01 to 0x100, then read 0x100 as client 1 -> data_out_valid LATENCY cycles after the read, same line, client_id_out=1.
REQ-040 Same-cycle rden+wren to 0x200 with data 0xA5..A5 -> response 0xA5..A5.
REQ-041 Five reads back-to-back with DEPTH=4 -> req_ready low on the fifth, pending_count=4; after the first response the fifth is accepted, and all five return in order, LATENCY apart.
REQ-042 Read accepted, en dropped for 3 cycles during WAIT -> response delayed by exactly 3 cycles, with no valid pulse while en=0.
REQ-043 Read 0x300, then write new data to 0x300 before the response -> response carries the old data.
REQ-044 Reset asserted with 3 reads pending -> no responses, pending_count=0, req_ready=1; with LINE_MEMORY_STATS_EN, rd_count=0.
